// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor with valid/ready flow control and RNE rounding.
// Stage 1 aligns the operands, stage 2 adds and counts leading zeros, stage 3 normalizes and rounds.
module fp_addsub_pipe #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out,
   output logic         ovf,
   output logic         unf,
   output logic         inx,
   output logic         nan
);

   localparam int FW   = MAN_W + 4;          // hidden + mantissa + G/R/S
   localparam int SW   = MAN_W + 5;          // FW plus carry
   localparam int LZ_W = $clog2(SW + 1);
   localparam logic [EXP_W-1:0] EMAX   = '1;
   localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(FW);
   localparam logic [W-1:0]     QNAN   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [FW-1:0]    mx;
      logic [FW-1:0]    my;
      logic             esub;
      logic             spec;
      logic             spec_nan;
      logic [W-1:0]     spec_val;
   } s1_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SW-1:0]    sum;
      logic [LZ_W-1:0]  lzc;
      logic             spec;
      logic             spec_nan;
      logic [W-1:0]     spec_val;
   } s2_t;

   typedef struct packed {
      logic [W-1:0] val;
      logic         ovf;
      logic         unf;
      logic         inx;
      logic         nan;
   } res_t;

   logic [3:1] vld_pipe;
   s1_t        s1_q, s1_d;
   s2_t        s2_q, s2_d;
   res_t       res_q, res_d;
   logic       advance;

   assign advance   = ~vld_pipe[3] | out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_pipe[3];
   assign out       = res_q.val;
   assign ovf       = res_q.ovf;
   assign unf       = res_q.unf;
   assign inx       = res_q.inx;
   assign nan       = res_q.nan;

   // ---------------- stage 1: unpack, classify, swap, align ----------------
   logic             sa, sb, sx, sy, swap;
   logic [EXP_W-1:0] ea, eb, ex_raw, ey_raw, ex, ey, de, sh;
   logic [MAN_W-1:0] fa, fb, fx, fy;
   logic             za, zb, ia, ib, na, nb;
   logic [2*FW-1:0]  ext;

   assign sa = A[W-1];
   assign sb = B[W-1] ^ sub;
   assign ea = A[W-2:MAN_W];
   assign eb = B[W-2:MAN_W];
   assign fa = A[MAN_W-1:0];
   assign fb = B[MAN_W-1:0];

   always_comb begin
      s1_d   = '0;
      za     = (ea == '0) && (fa == '0);
      zb     = (eb == '0) && (fb == '0);
      ia     = (ea == EMAX) && (fa == '0);
      ib     = (eb == EMAX) && (fb == '0);
      na     = (ea == EMAX) && (fa != '0);
      nb     = (eb == EMAX) && (fb != '0);
      swap   = {eb, fb} > {ea, fa};
      sx     = swap ? sb : sa;
      sy     = swap ? sa : sb;
      ex_raw = swap ? eb : ea;
      ey_raw = swap ? ea : eb;
      fx     = swap ? fb : fa;
      fy     = swap ? fa : fb;
      ex     = (ex_raw == '0) ? EXP_W'(1) : ex_raw;
      ey     = (ey_raw == '0) ? EXP_W'(1) : ey_raw;
      de     = ex - ey;
      // clamping at FW pushes all of Y past the round bit, leaving sticky only
      sh     = (de > SH_MAX) ? SH_MAX : de;
      ext    = {(ey_raw != '0), fy, 3'b000, {FW{1'b0}}} >> sh;
      s1_d.my   = {ext[2*FW-1:FW+1], ext[FW] | (|ext[FW-1:0])};
      s1_d.mx   = {(ex_raw != '0), fx, 3'b000};
      s1_d.sign = sx;
      s1_d.exp  = ex;
      s1_d.esub = sx ^ sy;
      if (na || nb || (ia && ib && (sa != sb))) begin
         s1_d.spec     = 1'b1;
         s1_d.spec_nan = 1'b1;
         s1_d.spec_val = QNAN;
      end else if (ia) begin
         s1_d.spec     = 1'b1;
         s1_d.spec_val = A;
      end else if (ib) begin
         s1_d.spec     = 1'b1;
         s1_d.spec_val = {sb, B[W-2:0]};
      end else if (za && zb) begin
         s1_d.spec     = 1'b1;
         s1_d.spec_val = {sa & sb, {(W-1){1'b0}}};
      end else if (za) begin
         s1_d.spec     = 1'b1;
         s1_d.spec_val = {sb, B[W-2:0]};
      end else if (zb) begin
         s1_d.spec     = 1'b1;
         s1_d.spec_val = A;
      end
   end

   // ---------------- stage 2: magnitude add/sub, leading-zero count ----------------
   logic [SW-1:0] sum;
   logic          found;

   always_comb begin
      sum   = s1_q.esub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                        : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});
      s2_d          = '0;
      s2_d.sign     = s1_q.sign;
      s2_d.exp      = s1_q.exp;
      s2_d.sum      = sum;
      s2_d.spec     = s1_q.spec;
      s2_d.spec_nan = s1_q.spec_nan;
      s2_d.spec_val = s1_q.spec_val;
      s2_d.lzc      = LZ_W'(SW);
      found         = 1'b0;
      for (int i = SW - 1; i >= 0; i--) begin
         if (!found && sum[i]) begin
            s2_d.lzc = LZ_W'(SW - 1 - i);
            found    = 1'b1;
         end
      end
   end

   // ---------------- stage 3: normalize, round, pack ----------------
   logic [EXP_W-1:0] lz_m1, e_m1, shamt;
   logic [FW-1:0]    m;
   logic [EXP_W:0]   en, efin;
   logic [MAN_W+1:0] rnd;
   logic [MAN_W-1:0] frac;
   logic             g, r, s, inc, inexact;

   always_comb begin
      lz_m1 = EXP_W'(s2_q.lzc) - EXP_W'(1);
      e_m1  = s2_q.exp - EXP_W'(1);
      // never shift below exponent 1: that is where gradual underflow starts
      shamt = (lz_m1 < e_m1) ? lz_m1 : e_m1;
      if (s2_q.sum[SW-1]) begin
         m  = {s2_q.sum[SW-1:2], s2_q.sum[1] | s2_q.sum[0]};
         en = {1'b0, s2_q.exp} + (EXP_W+1)'(1);
      end else begin
         m  = s2_q.sum[FW-1:0] << shamt;
         en = {1'b0, s2_q.exp - shamt};
      end
      if (!m[FW-1])
         en = '0;
      g       = m[2];
      r       = m[1];
      s       = m[0];
      inc     = g & (r | s | m[3]);
      inexact = g | r | s;
      rnd     = {1'b0, m[FW-1:3]} + (MAN_W+2)'(inc);
      // mantissa carry, or a denormal rounding up into the smallest normal
      efin    = en + (EXP_W+1)'(rnd[MAN_W+1] | ((en == '0) & rnd[MAN_W]));
      frac    = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

      res_d     = '0;
      res_d.val = {s2_q.sign, efin[EXP_W-1:0], frac};
      res_d.inx = inexact;
      res_d.unf = inexact && (efin == '0);
      if (efin >= {1'b0, EMAX}) begin
         res_d.val = {s2_q.sign, EMAX, {MAN_W{1'b0}}};
         res_d.ovf = 1'b1;
         res_d.inx = 1'b1;
         res_d.unf = 1'b0;
      end
      if (s2_q.sum == '0)
         res_d = '0;
      if (s2_q.spec) begin
         res_d     = '0;
         res_d.val = s2_q.spec_val;
         res_d.nan = s2_q.spec_nan;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         res_q    <= '0;
      end else if (advance) begin
         vld_pipe <= {vld_pipe[2:1], in_valid};
         if (in_valid)    s1_q  <= s1_d;
         if (vld_pipe[1]) s2_q  <= s2_d;
         if (vld_pipe[2]) res_q <= res_d;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed vectors, backpressure stream, mid-flight reset.
module tb_fp_addsub_pipe;

   logic        clk, rst, in_valid, in_ready, sub, out_valid, out_ready;
   logic [31:0] A, B, out;
   logic        ovf, unf, inx, nan;

   int checks = 0;
   int errors = 0;
   logic [35:0] sbq[$];

   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .ovf(ovf), .unf(unf), .inx(inx), .nan(nan)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // expected word: {out, ovf, unf, inx, nan}
   function automatic logic [35:0] E(input logic [31:0] v, input logic [3:0] f);
      return {v, f};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // monitor: pops one expected result per output transfer
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result got %h/%b", out, {ovf, unf, inx, nan});
         end else begin
            logic [35:0] e;
            e = sbq.pop_front();
            if ({out, ovf, unf, inx, nan} !== e) begin
               errors++;
               $display("FAIL result got %h/%b expected %h/%b",
                        out, {ovf, unf, inx, nan}, e[35:4], e[3:0]);
            end
         end
      end
   end

   // called at posedge+1; returns at posedge+1 after the transfer edge
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [35:0] exp);
      A = a; B = b; sub = s; in_valid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (in_ready) begin
            sbq.push_back(exp);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL send_timeout got in_ready=0 expected 1");
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 200; n++) begin
         if (sbq.size() == 0) break;
         @(negedge clk);
      end
      if (sbq.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout got %0d pending expected 0", sbq.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic latency(input string name);
      logic [2:0] seen;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         seen[i] = out_valid;
      end
      chk(name, 64'(seen), 64'(3'b100));
   endtask

   logic [31:0] st_a[10] = '{32'h40000000, 32'h40400000, 32'h41200000, 32'h3F000000,
                             32'hC0000000, 32'h00000000, 32'h80000000, 32'h3F800000,
                             32'h42C80000, 32'h7F800001};
   logic [31:0] st_b[10] = '{32'h40000000, 32'h3F800000, 32'h40A00000, 32'h3E800000,
                             32'h3F800000, 32'h12345678, 32'h80000000, 32'h80000000,
                             32'h42C80000, 32'h3F800000};
   logic        st_s[10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
   logic [31:0] st_r[10] = '{32'h40800000, 32'h40800000, 32'h40A00000, 32'h3F400000,
                             32'hBF800000, 32'h12345678, 32'h80000000, 32'h3F800000,
                             32'h43480000, 32'h7FC00000};
   logic [3:0]  st_f[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; sub = 1'b0;
      #12;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out", 64'(out), 64'd0);
      chk("reset_flags", 64'({ovf, unf, inx, nan}), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      send(32'h3F800000, 32'h40000000, 1'b0, E(32'h40400000, 4'b0000));
      latency("latency_add");
      drain();
      send(32'h3F800000, 32'h40000000, 1'b1, E(32'hBF800000, 4'b0000));
      send(32'h3F800000, 32'h33800000, 1'b0, E(32'h3F800000, 4'b0010));
      send(32'h3F800001, 32'h33800000, 1'b0, E(32'h3F800002, 4'b0010));
      send(32'h3F800000, 32'h3F800000, 1'b1, E(32'h00000000, 4'b0000));
      send(32'h00000001, 32'h00000001, 1'b0, E(32'h00000002, 4'b0000));
      send(32'h00800000, 32'h00000001, 1'b1, E(32'h007FFFFF, 4'b0000));
      send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, E(32'h7F800000, 4'b1010));
      send(32'h7F800000, 32'hFF800000, 1'b0, E(32'h7FC00000, 4'b0001));
      send(32'h7F800000, 32'h3F800000, 1'b0, E(32'h7F800000, 4'b0000));
      drain();

      // back-to-back stream with a 5-cycle downstream stall
      fork
         begin
            for (int i = 0; i < 10; i++)
               send(st_a[i], st_b[i], st_s[i], E(st_r[i], st_f[i]));
         end
         begin
            logic [35:0] snap;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (i == 0) begin
                  snap = {out, ovf, unf, inx, nan};
                  chk("stall_out_valid", 64'(out_valid), 64'd1);
               end else begin
                  chk("stall_hold", 64'({out, ovf, unf, inx, nan}), 64'(snap));
               end
               if (i == 4) chk("stall_in_ready", 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // reset with three operations in flight
      send(32'h3F800000, 32'h40000000, 1'b0, E(32'h40400000, 4'b0000));
      send(32'h3F800000, 32'h3F800000, 1'b0, E(32'h40000000, 4'b0000));
      send(32'h40000000, 32'h40000000, 1'b0, E(32'h40800000, 4'b0000));
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out", 64'({out, ovf, unf, inx, nan}), 64'd0);
      sbq.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      send(32'h40400000, 32'h3F800000, 1'b1, E(32'h40000000, 4'b0000));
      latency("latency_after_reset");
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
